// File: rtl/audio_clip_sequencer.sv
// audio_clip_sequencer
//
// Sample-rate scheduler that shares one single-port clip ROM between three
// sources: a looping background song, a one-shot jump effect and a one-shot
// game-over effect. On every sample tick it picks one source by fixed
// priority (over > jump > song). It fetches one sample from the ROM and
// presents it to the audio controller's write handshake. That sample drives
// both DAC channels.
//
// Ports:
//   CLOCK_50           system clock
//   resetn             asynchronous active-low reset
//   enable             sound enable; 0 writes silence every tick
//   song_req           level: song plays while high, pauses while low
//   jump_req           one-cycle pulse starting the jump effect
//   over_req           one-cycle pulse starting the game-over effect
//   rom_addr           clip ROM address (ROM has one cycle of read latency)
//   rom_q              clip ROM data
//   audio_out_allowed  audio controller FIFO has space
//   write_audio_out    one-cycle write strobe to the audio controller
//   sample_out         sample for both left and right channels
//   active_src         source of the current sample: 0 none, 1 song, 2 jump, 3 over
//   sfx_busy           jump or game-over effect in progress
//   drop_cnt           saturating count of ticks dropped while busy
module audio_clip_sequencer #(
    parameter int CLK_DIV    = 1042,
    parameter int ADDR_W     = 20,
    parameter int SAMPLE_W   = 6,
    parameter int SONG_BASE  = 0,
    parameter int SONG_LEN   = 633868,
    parameter int JUMP_BASE  = 633868,
    parameter int JUMP_LEN   = 12000,
    parameter int OVER_BASE  = 645868,
    parameter int OVER_LEN   = 48000,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                enable,
    input  logic                song_req,
    input  logic                jump_req,
    input  logic                over_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         sample_out,
    output logic [1:0]          active_src,
    output logic                sfx_busy,
    output logic [7:0]          drop_cnt
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    localparam logic [ADDR_W-1:0] SONG_FIRST = ADDR_W'(SONG_BASE);
    localparam logic [ADDR_W-1:0] SONG_LAST  = ADDR_W'(SONG_BASE + SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] JUMP_FIRST = ADDR_W'(JUMP_BASE);
    localparam logic [ADDR_W-1:0] JUMP_LAST  = ADDR_W'(JUMP_BASE + JUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] OVER_FIRST = ADDR_W'(OVER_BASE);
    localparam logic [ADDR_W-1:0] OVER_LAST  = ADDR_W'(OVER_BASE + OVER_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_SONG = 2'd1;
    localparam logic [1:0] SRC_JUMP = 2'd2;
    localparam logic [1:0] SRC_OVER = 2'd3;

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [2:0]        state;
    logic [1:0]        sel;
    logic [1:0]        next_src;
    logic              accept;
    logic              jump_pend, over_pend;
    logic              jump_active, over_active;
    logic              jump_pend_eff, over_pend_eff;
    logic [ADDR_W-1:0] song_ptr, jump_ptr, over_ptr;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [31:0]       rom_ext;

    assign tick   = (tick_cnt == CNT_MAX);
    assign accept = tick && (state == S_IDLE);

    // A request pulse that lands on the tick cycle counts as already pending.
    assign jump_pend_eff = jump_pend | jump_req;
    assign over_pend_eff = over_pend | over_req;

    assign sfx_busy        = jump_active | over_active;
    assign write_audio_out = (state == S_WRITE) && audio_out_allowed;
    assign rom_ext         = 32'(rom_q);

    always_comb begin
        next_src = SRC_NONE;
        if (!enable)
            next_src = SRC_NONE;
        else if (over_pend_eff || over_active)
            next_src = SRC_OVER;
        else if (jump_pend_eff || jump_active)
            next_src = SRC_JUMP;
        else if (song_req)
            next_src = SRC_SONG;
    end

    always_comb begin
        fetch_ptr = song_ptr;
        case (sel)
            SRC_JUMP: fetch_ptr = jump_ptr;
            SRC_OVER: fetch_ptr = over_ptr;
            default:  fetch_ptr = song_ptr;
        endcase
    end

    // Free-running sample-rate divider; it keeps counting while disabled.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    // Pending flags, effect activity and the three address pointers.
    // Pending requests are consumed only when their source wins a tick. Then
    // the pointer restarts at BASE. Pointers advance only in LATCH, which can
    // never coincide with an accepted tick.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            jump_pend   <= 1'b0;
            over_pend   <= 1'b0;
            jump_active <= 1'b0;
            over_active <= 1'b0;
            song_ptr    <= SONG_FIRST;
            jump_ptr    <= JUMP_FIRST;
            over_ptr    <= OVER_FIRST;
        end else begin
            jump_pend <= jump_pend_eff;
            over_pend <= over_pend_eff;
            if (accept && next_src == SRC_OVER && over_pend_eff) begin
                // A new game-over request restarts it and kills any jump.
                over_pend   <= 1'b0;
                over_active <= 1'b1;
                over_ptr    <= OVER_FIRST;
                jump_pend   <= 1'b0;
                jump_active <= 1'b0;
                jump_ptr    <= JUMP_FIRST;
            end else if (accept && next_src == SRC_JUMP && jump_pend_eff) begin
                jump_pend   <= 1'b0;
                jump_active <= 1'b1;
                jump_ptr    <= JUMP_FIRST;
            end
            if (state == S_LATCH) begin
                case (sel)
                    SRC_SONG: begin
                        if (song_ptr == SONG_LAST)
                            song_ptr <= SONG_FIRST;
                        else
                            song_ptr <= song_ptr + ADDR_W'(1);
                    end
                    SRC_JUMP: begin
                        if (jump_ptr == JUMP_LAST) begin
                            jump_ptr    <= JUMP_FIRST;
                            jump_active <= 1'b0;
                        end else begin
                            jump_ptr <= jump_ptr + ADDR_W'(1);
                        end
                    end
                    SRC_OVER: begin
                        if (over_ptr == OVER_LAST) begin
                            over_ptr    <= OVER_FIRST;
                            over_active <= 1'b0;
                        end else begin
                            over_ptr <= over_ptr + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Fetch sequencer. A silent (none) slot skips the ROM wait and writes zero.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            sel        <= SRC_NONE;
            rom_addr   <= SONG_FIRST;
            sample_out <= '0;
            active_src <= SRC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        sel   <= next_src;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    active_src <= sel;
                    if (sel == SRC_NONE) begin
                        state <= S_LATCH;
                    end else begin
                        rom_addr <= fetch_ptr;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: state <= S_LATCH;
                S_LATCH: begin
                    if (sel == SRC_NONE)
                        sample_out <= '0;
                    else
                        sample_out <= rom_ext << GAIN_SHIFT;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (audio_out_allowed)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Ticks arriving mid-transaction are lost; count them, saturating.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            drop_cnt <= '0;
        else if (tick && state != S_IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// tb_audio_clip_sequencer
//
// Scoreboard bench for audio_clip_sequencer. The stimulus process pushes the
// expected (address, source, busy, sample) of every upcoming write into a
// queue. A monitor pops an entry on each write strobe and compares it.
// Small parameters are used so wraps and effect endings happen quickly:
// the song is 7 samples, jump 2 at 16, over 3 at 32, tick every 6 cycles,
// gain shift 2. The ROM model returns (addr*5+3) mod 64 one cycle late.
module tb_audio_clip_sequencer;

    localparam int CLK_DIV = 6;
    localparam int GAIN    = 2;

    typedef struct {
        logic [7:0]  addr;
        logic        chk_addr;
        logic [1:0]  src;
        logic        busy;
        logic [31:0] sample;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        enable, song_req, jump_req, over_req;
    logic [7:0]  rom_addr;
    logic [5:0]  rom_q;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] sample_out;
    logic [1:0]  active_src;
    logic        sfx_busy;
    logic [7:0]  drop_cnt;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    audio_clip_sequencer #(
        .CLK_DIV(CLK_DIV), .ADDR_W(8), .SAMPLE_W(6),
        .SONG_BASE(0), .SONG_LEN(7),
        .JUMP_BASE(16), .JUMP_LEN(2),
        .OVER_BASE(32), .OVER_LEN(3),
        .GAIN_SHIFT(GAIN)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .enable(enable),
        .song_req(song_req),
        .jump_req(jump_req),
        .over_req(over_req),
        .rom_addr(rom_addr),
        .rom_q(rom_q),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out(write_audio_out),
        .sample_out(sample_out),
        .active_src(active_src),
        .sfx_busy(sfx_busy),
        .drop_cnt(drop_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [5:0] rom_fn(input logic [7:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd5 + 16'd3;
        return t[5:0];
    endfunction

    always @(posedge CLOCK_50) rom_q <= rom_fn(rom_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic song, input logic allowed);
        enable            = en;
        song_req          = song;
        audio_out_allowed = allowed;
    endtask

    task automatic pushExp(input logic [7:0] addr, input logic [1:0] src, input logic busy);
        exp_t e;
        e.addr     = addr;
        e.chk_addr = (src != 2'd0);
        e.src      = src;
        e.busy     = busy;
        e.sample   = (src == 2'd0) ? 32'd0 : (32'(rom_fn(addr)) << GAIN);
        exp_q.push_back(e);
    endtask

    task automatic pushSong(input int first, input int count);
        for (int i = 0; i < count; i++)
            pushExp(8'((first + i) % 7), 2'd1, 1'b0);
    endtask

    task automatic pulseJump();
        jump_req = 1'b1;
        @(posedge CLOCK_50); #1;
        jump_req = 1'b0;
    endtask

    task automatic pulseOver();
        over_req = 1'b1;
        @(posedge CLOCK_50); #1;
        over_req = 1'b0;
    endtask

    // Returns one cycle after the n-th further write, i.e. before the next tick.
    task automatic waitWrites(input int n);
        int target;
        int budget;
        target = n_writes + n;
        budget = n * CLK_DIV * 3 + 40;
        while (n_writes < target && budget > 0) begin
            @(posedge CLOCK_50);
            budget--;
        end
        #1;
        if (n_writes < target)
            checkOutput("write timeout", 32'(n_writes), 32'(target));
    endtask

    // Monitor: every write strobe must match the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (write_audio_out) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_addr)
                    checkOutput("rom_addr", 32'(rom_addr), 32'(e.addr));
                checkOutput("sample_out", sample_out, e.sample);
                checkOutput("active_src", 32'(active_src), 32'(e.src));
                checkOutput("sfx_busy", 32'(sfx_busy), 32'(e.busy));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap;
        resetn   = 1'b0;
        jump_req = 1'b0;
        over_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset sample_out", sample_out, 32'd0);
        checkOutput("reset active_src", 32'(active_src), 32'd0);
        checkOutput("reset sfx_busy", 32'(sfx_busy), 32'd0);
        checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("reset write", 32'(write_audio_out), 32'd0);

        // Song playback including the wrap from address 6 back to 0.
        applyStimulus(1'b1, 1'b1, 1'b1);
        pushSong(0, 12);
        resetn = 1'b1;
        waitWrites(12);
        checkOutput("drop_cnt after song", 32'(drop_cnt), 32'd0);

        // Jump effect preempts the song at address 5, song then resumes.
        pulseJump();
        pushExp(8'd16, 2'd2, 1'b1);
        pushExp(8'd17, 2'd2, 1'b0);
        pushSong(5, 3);
        waitWrites(5);

        // Game-over during jump sample 0: jump is abandoned for good.
        pulseJump();
        pushExp(8'd16, 2'd2, 1'b1);
        waitWrites(1);
        pulseOver();
        pushExp(8'd32, 2'd3, 1'b1);
        pushExp(8'd33, 2'd3, 1'b1);
        pushExp(8'd34, 2'd3, 1'b0);
        pushSong(1, 2);
        waitWrites(5);

        // Back-pressure: song 3 waits in WRITE while two ticks are dropped.
        applyStimulus(1'b1, 1'b1, 1'b0);
        pushSong(3, 2);
        snap = n_writes;
        repeat (18) @(posedge CLOCK_50);
        #1;
        checkOutput("no write while blocked", 32'(n_writes), 32'(snap));
        checkOutput("held sample_out", sample_out, 32'(rom_fn(8'd3)) << GAIN);
        checkOutput("drop_cnt 2 or 3", 32'(drop_cnt == 8'd2 || drop_cnt == 8'd3), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitWrites(2);

        // Disabled: silence keeps flowing, a jump request stays pending.
        applyStimulus(1'b0, 1'b1, 1'b1);
        pushExp(8'd0, 2'd0, 1'b0);
        pushExp(8'd0, 2'd0, 1'b0);
        pushExp(8'd0, 2'd0, 1'b0);
        waitWrites(1);
        pulseJump();
        checkOutput("sfx_busy while disabled", 32'(sfx_busy), 32'd0);
        waitWrites(2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        pushExp(8'd16, 2'd2, 1'b1);
        pushExp(8'd17, 2'd2, 1'b0);
        pushSong(5, 1);
        waitWrites(3);
        checkOutput("final drop_cnt 2 or 3", 32'(drop_cnt == 8'd2 || drop_cnt == 8'd3), 32'd1);

        // Reset asserted while a write is being held off.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (6) @(posedge CLOCK_50);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("mid-write reset rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("mid-write reset sample_out", sample_out, 32'd0);
        checkOutput("mid-write reset active_src", 32'(active_src), 32'd0);
        checkOutput("mid-write reset drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("mid-write reset sfx_busy", 32'(sfx_busy), 32'd0);
        audio_out_allowed = 1'b1;
        #1;
        checkOutput("mid-write reset write", 32'(write_audio_out), 32'd0);
        snap = n_writes;
        repeat (4) @(posedge CLOCK_50);
        #1;
        checkOutput("no write in reset", 32'(n_writes), 32'(snap));
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
